m_uart_loader: RTL and testbench
================================

Name: m_uart_loader

Overview:
- Serial program loader that fills the 4K-word instruction/data memory over a UART line before the processor runs.
- Receives 8N1 frames, assembles little-endian 32-bit words and drives the memory write port (address, data, write enable).
- Holds the processor in reset (busy) until the image is complete.
- It is the writer end of the memory port that the processor fetch/load path reads.

Parameters:
- DIV, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
- ADDR_W, 12, memory word-address width; capacity = 2^ADDR_W words.

Ports:
- w_clk  in  1  system clock.
- w_rst_n  in  1  synchronous active-low reset.
- w_rxd  in  1  UART receive line, asynchronous, idle high.
- r_we  out  1  memory write enable, one-cycle pulse per word.
- r_addr  out  ADDR_W  memory word address.
- r_wdata  out  32  memory write data.
- r_busy  out  1  high while loading; drives processor reset.
- r_done  out  1  image fully written (sticky).
- r_err  out  1  framing or length error (sticky).
- r_nword  out  ADDR_W+1  number of words written so far.

Behaviour:
- Reset values (w_rst_n low at a posedge): r_we=0, r_addr=0, r_wdata=0, r_busy=1, r_done=0, r_err=0, r_nword=0. The receiver returns to RX_IDLE and the loader to L_LEN0.
- Reset mid-frame or mid-image discards all partial state. Memory contents already written are not restored.
- w_rxd passes through a 2-flop synchronizer before any use.
- Receiver FSM, states RX_IDLE, RX_START, RX_DATA, RX_STOP:
  - RX_IDLE: a synchronized falling edge enters RX_START.
  - RX_START: the line is sampled at DIV/2. If it is high, this was a glitch: return to RX_IDLE. If it is low, go to RX_DATA.
  - RX_DATA: 8 bits are sampled LSB first, each DIV cycles apart.
  - RX_STOP: the stop bit is sampled DIV later. If it is high, a 1-cycle byte-valid pulse is emitted. If it is low, a framing-error pulse is emitted. Either way, return to RX_IDLE.
- Loader FSM, states L_LEN0, L_LEN1, L_WORD, L_DONE, L_ERR:
  - L_LEN0: the byte is the word count N, low byte.
  - L_LEN1: the byte is N, high byte.
    - N==0: go to L_DONE.
    - N > 2^ADDR_W: go to L_ERR.
    - Otherwise go to L_WORD.
  - L_WORD: bytes are shifted in little-endian. Byte k of a word goes to bits [8k+7:8k].
    - On the 4th byte: r_we=1 for exactly one cycle, r_addr=word index, r_wdata=assembled word. The pulse occurs in the cycle after the byte-valid pulse. r_nword increments in that same cycle.
    - After word N-1 is written, go to L_DONE.
  - L_DONE: r_busy=0 and r_done=1 from the cycle after the last r_we. Further serial input is ignored until reset.
  - L_ERR: r_err=1 and r_busy stays 1. Only reset exits.
- A framing error in any loading state goes to L_ERR. No write is issued for the partial word.
- Address order: 0,1,...,N-1. N == 2^ADDR_W writes the last address, 4095. r_addr never wraps to 0.
- The write protocol matches the memory's synchronous write: address, data and enable are valid together and are captured at the next posedge.
- Outside r_we pulses, r_addr and r_wdata hold their last values.

Decomposition:
- Shared package holds the constants below:
  - receiver state encodings RX_IDLE..RX_STOP;
  - loader state encodings L_LEN0..L_ERR;
  - default DIV constant (`UART_DIV).
- One sub-module, m_uart_rx, contains:
  - the synchronizer, bit counter, DIV counter and receiver FSM;
  - outputs: 8-bit data, 1-cycle valid, 1-cycle framing error.
- m_uart_loader instantiates m_uart_rx and holds the loader FSM, word assembly and write port.

Test Plan:
- Image load: DIV=8, send bytes 02 00, then 20 00 00 00, then 00 00 14 20. Expect r_we pulses at addr 0 with data 0x00000020, then addr 1 with 0x20140000. Expect r_nword=2, r_done=1, r_busy=0 one cycle after the second pulse, and no further pulses.
- Empty image: send 00 00. Expect r_done=1 with no r_we pulse and r_nword=0.
- Framing error: send 01 00, then two data bytes, then a byte whose stop bit is 0. Expect r_err=1, r_busy=1, no r_we, and no reaction to later bytes.
- Glitch and oversize length:
  - A low pulse of DIV/4 cycles on an idle line causes no byte.
  - Sending 01 10 (N=4097) sets r_err=1.
- Reset mid-word: assert w_rst_n=0 for one cycle after 2 bytes of word 0. Expect all outputs at reset values. A fresh 01 00 AA BB CC DD then writes 0xDDCCBBAA to addr 0.
- Full capacity: N=4096 with incrementing words. Expect the last write at addr 4095 (no wrap), r_nword=4096 and r_done=1.

Source files
------------

// File: rtl/m_uart_loader_pkg.sv
// Shared constants for the UART program loader: state encodings and the
// default bit period.
package m_uart_loader_pkg;

  // Clock cycles per UART bit at 50 MHz / 115200 baud.
  localparam int UART_DIV = 434;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    L_LEN0,
    L_LEN1,
    L_WORD,
    L_DONE,
    L_ERR
  } ld_state_t;

endpackage

// File: rtl/m_uart_rx.sv
// 8N1 UART receiver: synchronizes the line, finds the start bit, samples
// each bit in its middle and reports either a byte or a framing error.
module m_uart_rx
  import m_uart_loader_pkg::*;
#(
  parameter int DIV = UART_DIV
) (
  input  logic       w_clk,
  input  logic       w_rst_n,
  input  logic       w_rxd,
  output logic [7:0] r_data,
  output logic       r_valid,
  output logic       r_ferr
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

  logic            rxd_meta;
  logic            rxd_sync;
  logic            rxd_prev;
  rx_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;

  // Two-flop synchronizer plus one history flop for falling-edge detection;
  // all three reset to the idle (high) line level.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= w_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Receiver FSM: start-bit check at half a bit, then data and stop bits
  // one full bit apart; valid/ferr are single-cycle pulses.
  always_ff @(posedge w_clk) begin
    r_valid <= 1'b0;
    r_ferr  <= 1'b0;
    if (!w_rst_n) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      r_data  <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rxd_prev && !rxd_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_cnt <= '0;
            // A line already back high is a glitch, not a start bit.
            state   <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rxd_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rxd_sync) begin
              r_valid <= 1'b1;
              r_data  <= shreg;
            end else begin
              r_ferr <= 1'b1;
            end
            state <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/m_uart_loader.sv
// Serial program loader: reads a 16-bit word count and that many
// little-endian 32-bit words from the UART and writes them to memory,
// holding the processor in reset until the image is complete.
module m_uart_loader
  import m_uart_loader_pkg::*;
#(
  parameter int DIV    = UART_DIV,
  parameter int ADDR_W = 12
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_rxd,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [31:0]       r_wdata,
  output logic              r_busy,
  output logic              r_done,
  output logic              r_err,
  output logic [ADDR_W:0]   r_nword
);

  // Largest accepted word count: the full memory.
  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_ferr;

  ld_state_t       state;
  logic [7:0]      len_lo;
  logic [ADDR_W:0] len;
  logic [1:0]      byte_idx;
  logic [23:0]     asm_bytes;
  logic [15:0]     len_req;

  m_uart_rx #(
    .DIV(DIV)
  ) u_rx (
    .w_clk  (w_clk),
    .w_rst_n(w_rst_n),
    .w_rxd  (w_rxd),
    .r_data (rx_data),
    .r_valid(rx_valid),
    .r_ferr (rx_ferr)
  );

  // Requested word count as it would be once the high byte arrives.
  always_comb begin
    len_req = {rx_data, len_lo};
  end

  // Loader FSM with word assembly and the registered memory write port.
  always_ff @(posedge w_clk) begin
    r_we <= 1'b0;
    if (!w_rst_n) begin
      state     <= L_LEN0;
      len_lo    <= '0;
      len       <= '0;
      byte_idx  <= '0;
      asm_bytes <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_nword   <= '0;
    end else begin
      case (state)
        L_LEN0: begin
          if (rx_ferr) begin
            state <= L_ERR;
          end else if (rx_valid) begin
            len_lo <= rx_data;
            state  <= L_LEN1;
          end
        end
        L_LEN1: begin
          if (rx_ferr) begin
            state <= L_ERR;
          end else if (rx_valid) begin
            if (len_req == '0) begin
              state <= L_DONE;
            end else if ({1'b0, len_req} > CAP) begin
              state <= L_ERR;
            end else begin
              len      <= len_req[ADDR_W:0];
              byte_idx <= '0;
              state    <= L_WORD;
            end
          end
        end
        L_WORD: begin
          if (rx_ferr) begin
            // The partial word is dropped; nothing is written.
            state <= L_ERR;
          end else if (rx_valid) begin
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= r_nword[ADDR_W-1:0];
              r_wdata <= {rx_data, asm_bytes};
              r_nword <= r_nword + 1'b1;
              if (r_nword == len - 1'b1) state <= L_DONE;
            end else begin
              // Shift right so the first byte ends up in bits [7:0].
              asm_bytes <= {rx_data, asm_bytes[23:8]};
            end
          end
        end
        L_DONE: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        L_ERR: begin
          r_err <= 1'b1;
        end
        default: state <= L_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_m_uart_loader.sv
// Directed and randomized bench for m_uart_loader with a word-list model.
module tb_m_uart_loader;

  localparam int DIV    = 8;
  localparam int ADDR_W = 6;
  localparam int CAP    = 2 ** ADDR_W;

  logic              w_clk = 1'b0;
  logic              w_rst_n;
  logic              w_rxd;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_nword;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  int done_cyc = -1;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  logic [31:0]       exp_words[$];

  m_uart_loader #(
    .DIV   (DIV),
    .ADDR_W(ADDR_W)
  ) dut (
    .w_clk  (w_clk),
    .w_rst_n(w_rst_n),
    .w_rxd  (w_rxd),
    .r_we   (r_we),
    .r_addr (r_addr),
    .r_wdata(r_wdata),
    .r_busy (r_busy),
    .r_done (r_done),
    .r_err  (r_err),
    .r_nword(r_nword)
  );

  always #5 w_clk = ~w_clk;

  always @(posedge w_clk) cyc++;

  // Record every write pulse and the first cycle r_done is seen.
  always @(negedge w_clk) begin
    if (r_we) begin
      wq_addr.push_back(r_addr);
      wq_data.push_back(r_wdata);
      last_we_cyc = cyc;
    end
    if (r_done && done_cyc < 0) done_cyc = cyc;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge w_clk);
    w_rst_n = 1'b0;
    @(posedge w_clk);
    #1;
    check({tag, "_we"}, r_we, 1'b0);
    check({tag, "_addr"}, r_addr, '0);
    check({tag, "_wdata"}, r_wdata, '0);
    check({tag, "_busy"}, r_busy, 1'b1);
    check({tag, "_done"}, r_done, 1'b0);
    check({tag, "_err"}, r_err, 1'b0);
    check({tag, "_nword"}, r_nword, '0);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    wq_addr.delete();
    wq_data.delete();
    exp_words.delete();
    last_we_cyc = -1;
    done_cyc = -1;
  endtask

  // One 8N1 frame; stop selects the level driven during the stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    w_rxd = 1'b0;
    repeat (DIV) @(negedge w_clk);
    for (int i = 0; i < 8; i++) begin
      w_rxd = b[i];
      repeat (DIV) @(negedge w_clk);
    end
    w_rxd = stop;
    repeat (DIV) @(negedge w_clk);
    w_rxd = 1'b1;
    repeat (2) @(negedge w_clk);
  endtask

  task automatic send_len(input int n);
    logic [15:0] nn;
    nn = 16'(n);
    send_byte(nn[7:0]);
    send_byte(nn[15:8]);
  endtask

  task automatic send_words();
    logic [31:0] w;
    foreach (exp_words[i]) begin
      w = exp_words[i];
      for (int k = 0; k < 4; k++) send_byte(8'((w >> (8 * k)) & 32'hFF));
    end
  endtask

  // Compare the recorded writes and status against the expected image.
  task automatic check_image(input string tag, input int n);
    repeat (3 * DIV) @(negedge w_clk);
    check({tag, "_nwrites"}, wq_addr.size(), n);
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wq_addr[i], i);
      check($sformatf("%s_data%0d", tag, i), wq_data[i], exp_words[i]);
    end
    check({tag, "_nword"}, r_nword, n);
    check({tag, "_done"}, r_done, 1'b1);
    check({tag, "_busy"}, r_busy, 1'b0);
    check({tag, "_err"}, r_err, 1'b0);
    if (n > 0) begin
      check({tag, "_done_lat"}, done_cyc, last_we_cyc + 1);
      check({tag, "_hold_addr"}, r_addr, n - 1);
      check({tag, "_hold_data"}, r_wdata, exp_words[n-1]);
    end
  endtask

  task automatic check_error(input string tag);
    repeat (3 * DIV) @(negedge w_clk);
    check({tag, "_err"}, r_err, 1'b1);
    check({tag, "_busy"}, r_busy, 1'b1);
    check({tag, "_done"}, r_done, 1'b0);
    check({tag, "_nwrites"}, wq_addr.size(), 0);
    check({tag, "_nword"}, r_nword, 0);
  endtask

  initial begin
    int n;
    w_rst_n = 1'b0;
    w_rxd   = 1'b1;
    repeat (3) @(negedge w_clk);

    // Image load from the fixed example, then a late byte that must be ignored.
    do_reset("rst0");
    exp_words.push_back(32'h0000_0020);
    exp_words.push_back(32'h2014_0000);
    send_len(2);
    send_words();
    check_image("img", 2);
    send_byte(8'h55);
    check_image("img_after", 2);

    // Empty image.
    do_reset("rst1");
    send_len(0);
    check_image("empty", 0);

    // Framing error after two data bytes, then later traffic is ignored.
    do_reset("rst2");
    send_len(1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33, 1'b0);
    check_error("ferr");
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    check_error("ferr_after");

    // Short glitch must produce no byte: the following image still decodes.
    do_reset("rst3");
    w_rxd = 1'b0;
    repeat (DIV / 4) @(negedge w_clk);
    w_rxd = 1'b1;
    repeat (3 * DIV) @(negedge w_clk);
    exp_words.push_back($urandom);
    send_len(1);
    send_words();
    check_image("glitch", 1);

    // Oversize lengths: the example 0x1001 and one past capacity.
    do_reset("rst4");
    send_len(16'h1001);
    check_error("over4097");
    do_reset("rst5");
    send_len(CAP + 1);
    check_error("over_cap1");

    // Reset two bytes into word 0, then a fresh one-word image.
    do_reset("rst6");
    send_len(1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("midword_nowrite", wq_addr.size(), 0);
    do_reset("rst_mid");
    exp_words.push_back(32'hDDCC_BBAA);
    send_len(1);
    send_words();
    check_image("after_rst", 1);

    // Random small image.
    do_reset("rst7");
    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) exp_words.push_back($urandom);
    send_len(n);
    send_words();
    check_image("rand", n);

    // Full capacity: last address is CAP-1, no wrap.
    do_reset("rst8");
    for (int i = 0; i < CAP; i++) exp_words.push_back($urandom);
    send_len(CAP);
    send_words();
    check_image("full", CAP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
